// File: rtl/perf_counter_bank.sv
// rtl/perf_counter_bank.sv - bank of event/cycle counters with compare, sticky status and irq
// Each channel owns COUNT, COMPARE, CTRL and STATUS at address 4*c + k.
module perf_counter_bank #(
   parameter int WIDTH    = 32,
   parameter int CHANNELS = 4,
   parameter int ADDR_W   = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] ev_i,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [WIDTH-1:0]    wr_data,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic [WIDTH-1:0]    rd_data,
   output logic                irq
);

   logic [WIDTH-1:0]    count_v [CHANNELS];
   logic [WIDTH-1:0]    cmp_v   [CHANNELS];
   logic [3:0]          ctrl_v  [CHANNELS];
   logic [1:0]          stat_v  [CHANNELS];
   logic [CHANNELS-1:0] irq_v;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [WIDTH-1:0] count_q, count_d;
      logic [WIDTH-1:0] cmp_q, cmp_d;
      logic [3:0]       ctrl_q, ctrl_d;
      logic [1:0]       stat_q, stat_d;
      logic             hit_count, hit_cmp, hit_ctrl, hit_stat;
      logic             inc, at_max, fresh, match_set, ovf_set;

      assign hit_count = wr_en && (wr_addr == ADDR_W'(4*c));
      assign hit_cmp   = wr_en && (wr_addr == ADDR_W'(4*c + 1));
      assign hit_ctrl  = wr_en && (wr_addr == ADDR_W'(4*c + 2));
      assign hit_stat  = wr_en && (wr_addr == ADDR_W'(4*c + 3));

      always_comb begin
         count_d = count_q;
         fresh   = 1'b0;
         ovf_set = 1'b0;
         inc     = ctrl_q[0] & ev_i[c] & ~hit_count;
         at_max  = &count_q;
         if (hit_count) begin
            count_d = wr_data;
         end else if (inc) begin
            if (!at_max) begin
               count_d = count_q + WIDTH'(1);
               fresh   = 1'b1;
            end else begin
               ovf_set = 1'b1;
               if (!ctrl_q[1]) begin
                  count_d = '0;
                  fresh   = 1'b1;
               end
            end
         end
         // A saturated hold is not a new value, so only fresh values may match.
         match_set = fresh && (count_d == cmp_q);

         cmp_d = hit_cmp ? wr_data : cmp_q;

         ctrl_d = ctrl_q;
         if (match_set && ctrl_q[2]) ctrl_d[0] = 1'b0;
         if (hit_ctrl) ctrl_d = wr_data[3:0];

         stat_d = stat_q;
         if (hit_stat) stat_d = stat_q & ~wr_data[1:0];
         stat_d = stat_d | {ovf_set, match_set};
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            count_q <= '0;
            cmp_q   <= '1;
            ctrl_q  <= '0;
            stat_q  <= '0;
         end else begin
            count_q <= count_d;
            cmp_q   <= cmp_d;
            ctrl_q  <= ctrl_d;
            stat_q  <= stat_d;
         end
      end

      assign count_v[c] = count_q;
      assign cmp_v[c]   = cmp_q;
      assign ctrl_v[c]  = ctrl_q;
      assign stat_v[c]  = stat_q;
      assign irq_v[c]   = stat_q[0] & ctrl_q[3];
   end

   assign irq = |irq_v;

   logic [ADDR_W-1:0] rd_ch;
   assign rd_ch = rd_addr >> 2;

   always_comb begin
      rd_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (rd_ch == ADDR_W'(c)) begin
            case (rd_addr[1:0])
               2'd0: rd_data = count_v[c];
               2'd1: rd_data = cmp_v[c];
               2'd2: rd_data = WIDTH'(ctrl_v[c]);
               2'd3: rd_data = WIDTH'(stat_v[c]);
            endcase
         end
      end
   end

endmodule

// File: tb/tb_perf_counter_bank.sv
// tb/tb_perf_counter_bank.sv - self-checking bench for perf_counter_bank
// Directed test-plan scenarios against constants, then random traffic against a behavioural model.
module tb_perf_counter_bank;
   localparam int W  = 32;
   localparam int CH = 4;
   localparam int AW = 6;
   localparam logic [31:0] MAXV = 32'hFFFF_FFFF;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] ev_i = '0;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [W-1:0]  wr_data = '0;
   logic [AW-1:0] rd_addr = '0;
   logic [W-1:0]  rd_data;
   logic          irq;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_cnt  [CH];
   logic [31:0] m_cmp  [CH];
   logic [3:0]  m_ctrl [CH];
   logic [1:0]  m_stat [CH];

   perf_counter_bank #(.WIDTH(W), .CHANNELS(CH), .ADDR_W(AW)) dut (
      .clk(clk), .rst(rst), .ev_i(ev_i), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .irq(irq)
   );

   always #500 clk = ~clk;

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_cnt[c] = 0; m_cmp[c] = MAXV; m_ctrl[c] = 0; m_stat[c] = 0;
      end
   endtask

   task automatic model_step();
      logic [32:0] t;
      logic [31:0] nc;
      logic [3:0]  nct;
      logic [1:0]  ns;
      bit          fresh, ov, mt;
      for (int c = 0; c < CH; c++) begin
         fresh = 0; ov = 0;
         nc = m_cnt[c]; nct = m_ctrl[c]; ns = m_stat[c];
         if (wr_en && int'(wr_addr) == 4*c) begin
            nc = wr_data;
         end else if (m_ctrl[c][0] && ev_i[c]) begin
            t = {1'b0, m_cnt[c]} + 33'd1;
            if (t > {1'b0, MAXV}) begin
               ov = 1;
               if (!m_ctrl[c][1]) begin nc = t[31:0]; fresh = 1; end
            end else begin
               nc = t[31:0]; fresh = 1;
            end
         end
         mt = fresh && (nc == m_cmp[c]);
         if (mt && m_ctrl[c][2]) nct[0] = 1'b0;
         if (wr_en && int'(wr_addr) == 4*c + 2) nct = wr_data[3:0];
         if (wr_en && int'(wr_addr) == 4*c + 3) ns = ns & ~wr_data[1:0];
         if (mt) ns[0] = 1'b1;
         if (ov) ns[1] = 1'b1;
         if (wr_en && int'(wr_addr) == 4*c + 1) m_cmp[c] = wr_data;
         m_cnt[c] = nc; m_ctrl[c] = nct; m_stat[c] = ns;
      end
   endtask

   function automatic logic [31:0] m_read(int a);
      if (a >= 4*CH) return 0;
      case (a % 4)
         0: return m_cnt[a/4];
         1: return m_cmp[a/4];
         2: return {28'd0, m_ctrl[a/4]};
         default: return {30'd0, m_stat[a/4]};
      endcase
   endfunction

   function automatic logic m_irq();
      logic r = 0;
      for (int c = 0; c < CH; c++) r |= m_stat[c][0] & m_ctrl[c][3];
      return r;
   endfunction

   always @(posedge clk) if (!rst) model_step();

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int a, output logic [31:0] d);
      rd_addr = AW'(a);
      #1;
      d = rd_data;
   endtask

   task automatic wr(input int a, input logic [31:0] d);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      rst = 1'b1; model_reset();
      tick(); tick();
      #100 rst = 1'b0;
      for (int a = 0; a <= 4*CH; a++) begin
         e = (a < 4*CH && a % 4 == 1) ? MAXV : 32'd0;
         rd(a, d);
         total++; if (d !== e) begin bad++; $display("FAIL reset_reg[%0d]: got %h want %h", a, d, e); end
      end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
   endtask

   task automatic test_count();
      logic [31:0] d;
      wr(2, 32'h1);
      ev_i = 4'b0001;
      repeat (10) begin
         tick();
         total++; if (irq !== 1'b0) begin bad++; $display("FAIL count_irq: got %b want 0", irq); end
      end
      ev_i = '0;
      rd(0, d);
      total++; if (d !== 32'd10) begin bad++; $display("FAIL count0: got %0d want 10", d); end
      for (int c = 1; c < CH; c++) begin
         rd(4*c, d);
         total++; if (d !== 32'd0) begin bad++; $display("FAIL count_other[%0d]: got %0d want 0", c, d); end
      end
   endtask

   task automatic test_wrap();
      logic [31:0] d;
      wr(5, 32'h1234); wr(4, 32'hFFFF_FFFE); wr(6, 32'h1);
      ev_i = 4'b0010; tick(); ev_i = '0;
      rd(4, d);
      total++; if (d !== MAXV) begin bad++; $display("FAIL wrap_step1: got %h want ffffffff", d); end
      ev_i = 4'b0010; tick(); ev_i = '0;
      rd(4, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL wrap_step2: got %h want 0", d); end
      rd(7, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL wrap_status: got %h want 2", d); end
      wr(7, 32'h3); wr(6, 32'h3); wr(4, 32'hFFFF_FFFE);
      ev_i = 4'b0010; repeat (3) tick(); ev_i = '0;
      rd(4, d);
      total++; if (d !== MAXV) begin bad++; $display("FAIL sat_hold: got %h want ffffffff", d); end
      rd(7, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL sat_status: got %h want 2", d); end
      wr(7, 32'h3); wr(5, MAXV);
      ev_i = 4'b0010; repeat (2) tick(); ev_i = '0;
      rd(7, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL sat_held_nomatch: got %h want 2", d); end
      wr(6, 32'h0);
   endtask

   task automatic test_oneshot();
      logic [31:0] d;
      wr(9, 32'd5); wr(10, 32'hD);
      ev_i = 4'b0100;
      repeat (4) tick();
      rd(8, d);
      total++; if (d !== 32'd4) begin bad++; $display("FAIL oneshot_mid: got %0d want 4", d); end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early: got %b want 0", irq); end
      repeat (4) tick();
      rd(8, d);
      total++; if (d !== 32'd5) begin bad++; $display("FAIL oneshot_stop: got %0d want 5", d); end
      rd(10, d);
      total++; if (d !== 32'hC) begin bad++; $display("FAIL oneshot_ctrl: got %h want c", d); end
      rd(11, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_status: got %h want 1", d); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq: got %b want 1", irq); end
      wr(11, 32'h1);
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq: got %b want 0", irq); end
      rd(11, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_status: got %h want 0", d); end
      ev_i = '0;
   endtask

   task automatic test_collision();
      logic [31:0] d;
      ev_i = 4'b0001; wr(0, 32'd100); ev_i = '0;
      rd(0, d);
      total++; if (d !== 32'd100) begin bad++; $display("FAIL count_write_wins: got %0d want 100", d); end
      ev_i = 4'b0001; tick(); ev_i = '0;
      rd(0, d);
      total++; if (d !== 32'd101) begin bad++; $display("FAIL count_after_write: got %0d want 101", d); end
      wr(13, 32'd3); wr(12, 32'd2); wr(14, 32'h1);
      ev_i = 4'b1000; wr(15, 32'h3); ev_i = '0;
      rd(15, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL set_beats_w1c: got %h want 1", d); end
      rd(12, d);
      total++; if (d !== 32'd3) begin bad++; $display("FAIL collide_count3: got %0d want 3", d); end
      wr(15, 32'h1); wr(12, 32'd2); wr(14, 32'h5);
      ev_i = 4'b1000; wr(14, 32'h5); ev_i = '0;
      rd(14, d);
      total++; if (d !== 32'h5) begin bad++; $display("FAIL ctrl_write_wins: got %h want 5", d); end
      rd(15, d);
      total++; if (d !== 32'h1) begin bad++; $display("FAIL oneshot_collide_status: got %h want 1", d); end
   endtask

   task automatic test_async_reset();
      logic [31:0] d, e;
      wr(0, 32'd0); wr(1, 32'd3); wr(2, 32'h9); wr(6, 32'h1); wr(10, 32'h1);
      ev_i = 4'b1111;
      repeat (5) tick();
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
      #300 rst = 1'b1;
      model_reset();
      for (int a = 0; a <= 4*CH; a++) begin
         e = (a < 4*CH && a % 4 == 1) ? MAXV : 32'd0;
         rd(a, d);
         total++; if (d !== e) begin bad++; $display("FAIL async_reg[%0d]: got %h want %h", a, d, e); end
      end
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL async_irq: got %b want 0", irq); end
      tick();
      #200 rst = 1'b0;
      tick(); tick();
      rd(0, d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL no_count_after_reset: got %0d want 0", d); end
      ev_i = '0;
   endtask

   task automatic test_random();
      logic [31:0] d, e;
      int a;
      for (int i = 0; i < 300; i++) begin
         ev_i  = CH'($urandom);
         wr_en = $urandom_range(0, 1) == 1;
         a = ($urandom_range(0, 9) == 0) ? $urandom_range(16, 63) : $urandom_range(0, 15);
         wr_addr = AW'(a);
         case (a % 4)
            0, 1:    wr_data = $urandom_range(0, 1) ? 32'($urandom_range(0, 8)) : MAXV - 32'($urandom_range(0, 3));
            default: wr_data = $urandom;
         endcase
         tick();
         for (int r = 0; r <= 4*CH; r++) begin
            e = m_read(r);
            rd(r, d);
            total++; if (d !== e) begin bad++; $display("FAIL rand[%0d] reg %0d: got %h want %h", i, r, d, e); end
         end
         total++; if (irq !== m_irq()) begin bad++; $display("FAIL rand[%0d] irq: got %b want %b", i, irq, m_irq()); end
      end
      wr_en = 1'b0; ev_i = '0;
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_oneshot();
      test_collision();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
